// File: rtl/frame_slot_scheduler_if.sv
// frame_slot_scheduler_if: camera writer, reader lock and publish signals of frame_slot_scheduler.
// master drives the request pulses, slave (the scheduler) drives all status outputs.
interface frame_slot_scheduler_if #(parameter int SLOT_W = 3);
    logic                  wr_start;
    logic                  wr_done;
    logic                  wr_valid;
    logic [SLOT_W-1:0]     wr_slot;
    logic [24:0]           wr_base;
    logic [2:0]            rd_lock;
    logic [2:0]            rd_release;
    logic [2:0]            rd_valid;
    logic [3*SLOT_W-1:0]   rd_slot;
    logic [3*25-1:0]       rd_base;
    logic [SLOT_W-1:0]     last_slot;
    logic                  last_valid;
    logic                  frame_ready;
    logic                  frame_dropped;
    logic [15:0]           drop_count;

    modport master (
        output wr_start, wr_done, rd_lock, rd_release,
        input  wr_valid, wr_slot, wr_base, rd_valid, rd_slot, rd_base,
               last_slot, last_valid, frame_ready, frame_dropped, drop_count
    );

    modport slave (
        input  wr_start, wr_done, rd_lock, rd_release,
        output wr_valid, wr_slot, wr_base, rd_valid, rd_slot, rd_base,
               last_slot, last_valid, frame_ready, frame_dropped, drop_count
    );
endinterface

// File: rtl/frame_slot_scheduler.sv
// frame_slot_scheduler: DDR frame-slot allocation between camera writer and three locked readers.
// Define FRAME_SLOT_DROP_CNT_EN to enable the saturating dropped-frame counter.
module frame_slot_scheduler #(
    parameter int          NUM_SLOTS   = 4,
    parameter int          SLOT_W      = 3,
    parameter logic [24:0] BASE_ADDR   = 25'h0,
    parameter logic [24:0] SLOT_STRIDE = 25'h8000
) (
    input logic                   clk,
    input logic                   rst,
    frame_slot_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITING, DROP} state_t;

    state_t                state;
    logic [NUM_SLOTS-1:0]  busy;
    logic                  found;
    logic [SLOT_W-1:0]     free_slot;
    logic                  do_pub;
    logic                  do_drop;

    function automatic logic [24:0] base_of(input logic [SLOT_W-1:0] s);
        return BASE_ADDR + 25'(s) * SLOT_STRIDE;
    endfunction

    // The writer's own slot never blocks its next allocation, so it is left out here.
    always_comb begin
        busy = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            busy[s] = bus.last_valid && bus.last_slot == SLOT_W'(s);
            for (int i = 0; i < 3; i++)
                busy[s] = busy[s] | (bus.rd_valid[i] && bus.rd_slot[i*SLOT_W +: SLOT_W] == SLOT_W'(s));
        end
    end

    always_comb begin
        found     = 1'b0;
        free_slot = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--)
            if (!busy[s]) begin
                found     = 1'b1;
                free_slot = SLOT_W'(s);
            end
    end

    assign do_pub  = !bus.wr_start && bus.wr_done && state == WRITING;
    assign do_drop = !bus.wr_start && bus.wr_done && state == DROP;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state             <= IDLE;
            bus.wr_valid      <= 1'b0;
            bus.wr_slot       <= '0;
            bus.wr_base       <= BASE_ADDR;
            bus.last_slot     <= '0;
            bus.last_valid    <= 1'b0;
            bus.frame_ready   <= 1'b0;
            bus.frame_dropped <= 1'b0;
            bus.rd_valid      <= '0;
            bus.rd_slot       <= '0;
            bus.rd_base       <= {3{BASE_ADDR}};
        end else begin
            bus.frame_ready   <= do_pub;
            bus.frame_dropped <= do_drop;
            // A new start aborts any frame in flight; that frame is never published.
            if (bus.wr_start) begin
                state        <= found ? WRITING : DROP;
                bus.wr_valid <= found;
                if (found) begin
                    bus.wr_slot <= free_slot;
                    bus.wr_base <= base_of(free_slot);
                end
            end else if (do_pub) begin
                state          <= IDLE;
                bus.wr_valid   <= 1'b0;
                bus.last_slot  <= bus.wr_slot;
                bus.last_valid <= 1'b1;
            end else if (do_drop)
                state <= IDLE;
            // Readers see last_slot from before this edge, even if a publish happens now.
            for (int i = 0; i < 3; i++)
                if (bus.rd_lock[i] && bus.last_valid) begin
                    bus.rd_valid[i]                <= 1'b1;
                    bus.rd_slot[i*SLOT_W +: SLOT_W] <= bus.last_slot;
                    bus.rd_base[i*25 +: 25]        <= base_of(bus.last_slot);
                end else if (bus.rd_release[i])
                    bus.rd_valid[i] <= 1'b0;
        end

`ifdef FRAME_SLOT_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst)
            bus.drop_count <= '0;
        else if (do_drop && bus.drop_count != 16'hFFFF)
            bus.drop_count <= bus.drop_count + 16'd1;
`else
    assign bus.drop_count = 16'h0;
`endif
endmodule

// File: tb/tb_frame_slot_scheduler.sv
// tb_frame_slot_scheduler: directed vectors for frame_slot_scheduler (NUM_SLOTS=4, stride 0x8000).
module tb_frame_slot_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

`ifdef FRAME_SLOT_DROP_CNT_EN
    localparam logic [15:0] DROPS = 16'd1;
`else
    localparam logic [15:0] DROPS = 16'd0;
`endif

    frame_slot_scheduler_if #(.SLOT_W(3)) bus ();

    frame_slot_scheduler #(
        .NUM_SLOTS(4), .SLOT_W(3), .BASE_ADDR(25'h0), .SLOT_STRIDE(25'h8000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic d, input logic [2:0] l, input logic [2:0] r);
        @(negedge clk);
        bus.wr_start   = s;
        bus.wr_done    = d;
        bus.rd_lock    = l;
        bus.rd_release = r;
        @(posedge clk);
        #1;
        bus.wr_start   = 1'b0;
        bus.wr_done    = 1'b0;
        bus.rd_lock    = 3'b0;
        bus.rd_release = 3'b0;
    endtask

    initial begin
        bus.wr_start   = 1'b0;
        bus.wr_done    = 1'b0;
        bus.rd_lock    = 3'b0;
        bus.rd_release = 3'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_valid", bus.wr_valid, 0);
        chk("rst_wr_base", bus.wr_base, 0);
        chk("rst_last_valid", bus.last_valid, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_base", bus.rd_base, 0);
        chk("rst_drop_count", bus.drop_count, 0);
        @(negedge clk) rst = 1'b0;

        // first frame
        step(1, 0, 3'b000, 3'b000);
        chk("f1_wr_valid", bus.wr_valid, 1);
        chk("f1_wr_slot", bus.wr_slot, 0);
        chk("f1_wr_base", bus.wr_base, 25'h0);
        chk("f1_ready_early", bus.frame_ready, 0);
        step(0, 1, 3'b000, 3'b000);
        chk("f1_last_slot", bus.last_slot, 0);
        chk("f1_last_valid", bus.last_valid, 1);
        chk("f1_ready", bus.frame_ready, 1);
        chk("f1_wr_valid_drop", bus.wr_valid, 0);
        step(0, 0, 3'b000, 3'b000);
        chk("f1_ready_one_cycle", bus.frame_ready, 0);

        // rotation without readers: 0, 1, 0
        step(1, 0, 3'b000, 3'b000);
        chk("rot2_slot", bus.wr_slot, 1);
        chk("rot2_base", bus.wr_base, 25'h8000);
        step(0, 1, 3'b000, 3'b000);
        chk("rot2_last", bus.last_slot, 1);
        step(1, 0, 3'b000, 3'b000);
        chk("rot3_slot", bus.wr_slot, 0);
        step(0, 1, 3'b000, 3'b000);
        chk("rot3_last", bus.last_slot, 0);

        // VGA lock on slot 0, HDR lock on slot 1
        step(0, 0, 3'b001, 3'b000);
        chk("vga_valid", bus.rd_valid, 3'b001);
        chk("vga_slot", bus.rd_slot[2:0], 0);
        step(1, 0, 3'b000, 3'b000);
        chk("lk1_slot", bus.wr_slot, 1);
        step(0, 1, 3'b000, 3'b000);
        step(0, 0, 3'b010, 3'b000);
        chk("hdr_slot", bus.rd_slot[5:3], 1);
        chk("hdr_base", bus.rd_base[49:25], 25'h8000);
        step(1, 0, 3'b000, 3'b000);
        chk("lk2_slot", bus.wr_slot, 2);
        chk("lk2_base", bus.wr_base, 25'h10000);
        step(0, 1, 3'b000, 3'b000);
        chk("lk2_last", bus.last_slot, 2);
        step(1, 0, 3'b000, 3'b000);
        chk("lk3_slot", bus.wr_slot, 3);
        chk("lk3_base", bus.wr_base, 25'h18000);
        chk("vga_base_held", bus.rd_base[24:0], 25'h0);

        // UART locks 2, slot 3 published, then every slot is busy
        step(0, 0, 3'b100, 3'b000);
        chk("uart_slot", bus.rd_slot[8:6], 2);
        step(0, 1, 3'b000, 3'b000);
        chk("drop_pre_last", bus.last_slot, 3);
        step(1, 0, 3'b000, 3'b000);
        chk("drop_wr_valid", bus.wr_valid, 0);
        step(0, 1, 3'b000, 3'b000);
        chk("drop_pulse", bus.frame_dropped, 1);
        chk("drop_no_ready", bus.frame_ready, 0);
        chk("drop_last_kept", bus.last_slot, 3);
        chk("drop_count", bus.drop_count, DROPS);
        step(0, 0, 3'b000, 3'b000);
        chk("drop_pulse_end", bus.frame_dropped, 0);

        // release all, then build up last_slot=1 with writer on 2
        step(0, 0, 3'b000, 3'b111);
        chk("rel_all", bus.rd_valid, 3'b000);
        chk("rel_slot_kept", bus.rd_slot[8:6], 2);
        step(1, 0, 3'b000, 3'b000);
        chk("rb0_slot", bus.wr_slot, 0);
        step(0, 1, 3'b000, 3'b000);
        step(0, 0, 3'b001, 3'b000);
        step(1, 0, 3'b000, 3'b000);
        chk("rb1_slot", bus.wr_slot, 1);
        step(0, 1, 3'b000, 3'b000);
        step(1, 0, 3'b000, 3'b000);
        chk("rb2_slot", bus.wr_slot, 2);
        step(0, 1, 3'b010, 3'b000);
        chk("col_last", bus.last_slot, 2);
        chk("col_hdr_old", bus.rd_slot[5:3], 1);
        step(0, 0, 3'b001, 3'b001);
        chk("col_lock_wins", bus.rd_valid, 3'b011);
        chk("col_vga_moved", bus.rd_slot[2:0], 2);
        chk("col_vga_base", bus.rd_base[24:0], 25'h10000);

        // abort: writer on 1, a lower slot frees, restart picks 0
        step(0, 0, 3'b000, 3'b011);
        step(1, 0, 3'b000, 3'b000);
        chk("ab0_slot", bus.wr_slot, 0);
        step(0, 1, 3'b000, 3'b000);
        step(0, 0, 3'b100, 3'b000);
        step(1, 0, 3'b000, 3'b000);
        chk("ab1_slot", bus.wr_slot, 1);
        step(0, 1, 3'b000, 3'b000);
        step(1, 0, 3'b000, 3'b000);
        chk("ab2_slot", bus.wr_slot, 2);
        step(0, 1, 3'b000, 3'b000);
        step(1, 0, 3'b000, 3'b000);
        chk("ab_writing_1", bus.wr_slot, 1);
        step(0, 0, 3'b000, 3'b100);
        chk("ab_uart_rel", bus.rd_valid, 3'b000);
        step(1, 0, 3'b000, 3'b000);
        chk("ab_new_slot", bus.wr_slot, 0);
        chk("ab_new_valid", bus.wr_valid, 1);
        chk("ab_not_published", bus.last_slot, 2);
        step(0, 1, 3'b000, 3'b000);
        chk("ab_pub_slot", bus.last_slot, 0);
        chk("ab_pub_ready", bus.frame_ready, 1);
        step(0, 1, 3'b000, 3'b000);
        chk("idle_done_ready", bus.frame_ready, 0);
        chk("idle_done_last", bus.last_slot, 0);

        // asynchronous reset mid-frame
        step(1, 0, 3'b000, 3'b000);
        chk("mid_slot", bus.wr_slot, 1);
        step(0, 0, 3'b001, 3'b000);
        chk("mid_lock", bus.rd_valid, 3'b001);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_wr_valid", bus.wr_valid, 0);
        chk("arst_wr_slot", bus.wr_slot, 0);
        chk("arst_wr_base", bus.wr_base, 0);
        chk("arst_last_valid", bus.last_valid, 0);
        chk("arst_last_slot", bus.last_slot, 0);
        chk("arst_rd_valid", bus.rd_valid, 0);
        chk("arst_rd_slot", bus.rd_slot, 0);
        chk("arst_rd_base", bus.rd_base, 0);
        chk("arst_drop_count", bus.drop_count, 0);
        @(negedge clk) rst = 1'b0;
        step(0, 1, 3'b000, 3'b000);
        chk("post_rst_done", bus.frame_ready, 0);
        chk("post_rst_idle", bus.last_valid, 0);
        step(0, 0, 3'b001, 3'b000);
        chk("post_rst_lock_ign", bus.rd_valid, 3'b000);
        step(1, 0, 3'b000, 3'b000);
        chk("post_rst_slot", bus.wr_slot, 0);
        chk("post_rst_valid", bus.wr_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/frame_slot_scheduler.md
# frame_slot_scheduler

Allocates DDR frame-buffer slots between the camera write path and the three frame readers (VGA row buffer, HDR image generator, UART dump) in the 133 MHz memory domain. It hands the camera writer a free slot base address per frame and publishes the newest complete frame. It also lets each reader lock a stable frame, so no slot is overwritten while it is being read. It replaces ad-hoc `last_frame` passing with explicit lock/release bookkeeping.

## Interface

- `NUM_SLOTS`, 4: number of frame slots in DDR; legal range 4–8.
- `SLOT_W`, 3: slot index width; must satisfy 2^SLOT_W ≥ NUM_SLOTS.
- `BASE_ADDR`, 25'h0: DDR word address of slot 0.
- `SLOT_STRIDE`, 25'h8000: words per slot; ≥ 19200, which is one 640×480×16-bit frame in 256-bit words.

Ports:
- `clk` in 1: 133 MHz memory clock.
- `rst` in 1: asynchronous, active-high reset.
- `wr_start` in 1: one-cycle pulse when the camera begins a frame.
- `wr_done` in 1: one-cycle pulse when the camera frame is fully stored.
- `wr_valid` out 1: writer holds a slot; the camera may issue writes.
- `wr_slot` out SLOT_W: slot owned by the writer.
- `wr_base` out 25: `BASE_ADDR + wr_slot*SLOT_STRIDE`.
- `rd_lock` in 3: per-reader lock request pulse; bit0 = VGA, bit1 = HDR, bit2 = UART.
- `rd_release` in 3: per-reader release pulse.
- `rd_valid` out 3: reader i holds a locked slot.
- `rd_slot` out 3*SLOT_W: reader i slot in bits [i*SLOT_W +: SLOT_W].
- `rd_base` out 3*25: reader i base address in bits [i*25 +: 25].
- `last_slot` out SLOT_W: newest published complete frame.
- `last_valid` out 1: at least one frame has been published.
- `frame_ready` out 1: one-cycle pulse on publish.
- `frame_dropped` out 1: one-cycle pulse when a frame completes without a slot.
- `drop_count` out 16: dropped-frame counter (see Configuration).

## Operation

- The writer FSM has three states: IDLE, WRITING and DROP.
- A slot is **busy** if any of the following holds:
  - it equals `last_slot` while `last_valid`=1;
  - it is held by a reader with `rd_valid[i]`=1;
  - it is `wr_slot` while in WRITING.
- **Allocation on `wr_start`**, in any state: search for the lowest-index slot that is not busy. The writer's own current slot is excluded from busy for this search.
  - If a slot is found, the next state is WRITING; `wr_slot`/`wr_base` are registered and `wr_valid`=1.
  - If no slot is found, the next state is DROP and `wr_valid`=0.
- **`wr_start` while WRITING**: the current frame is aborted and never published, then allocation repeats.
- **`wr_done` in WRITING**:
  - `last_slot` ← `wr_slot` and `last_valid` ← 1.
  - `frame_ready` pulses and `wr_valid` drops.
  - The next state is IDLE.
- **`wr_done` in DROP**: `frame_dropped` pulses and the next state is IDLE. `last_slot` is unchanged.
- **`wr_done` in IDLE**: ignored.
- **Reader lock**: `rd_lock[i]` with `last_valid`=1 sets `rd_slot[i]` ← `last_slot` and `rd_valid[i]` ← 1.
  - If the reader already holds a slot, it moves to the newest frame and the old slot is implicitly released.
  - With `last_valid`=0 the lock is ignored and `rd_valid[i]` stays 0.
- **Reader release**: `rd_release[i]` clears `rd_valid[i]`. `rd_slot[i]` keeps its value.
- **Simultaneous lock and release** on the same reader: lock wins.
- **Simultaneous `wr_done` and `rd_lock`**: the reader gets the pre-update `last_slot`, not the frame just completed.
- **Simultaneous `wr_start` and `rd_lock`/`rd_release`**: allocation uses the registered busy state from before that edge.
- With NUM_SLOTS ≥ 5 DROP is unreachable. With 4 slots it occurs only when three readers and the published frame cover all other slots.

## Timing

- Reset values:
  - 0: `wr_valid`, `wr_slot`, `last_slot`, `last_valid`, `rd_valid`, `rd_slot`, `frame_ready`, `frame_dropped`, `drop_count`.
  - `wr_base` and every `rd_base` field: `BASE_ADDR`.
  - FSM state: IDLE.
- Allocation latency: `wr_valid`, `wr_slot` and `wr_base` are valid in the cycle after `wr_start` is sampled.
- Publish latency: `last_slot`, `last_valid` and `frame_ready` update in the cycle after `wr_done`.
- Lock/release latency: `rd_valid`, `rd_slot` and `rd_base` update in the cycle after the pulse.
- All outputs are registered; there is no combinational input-to-output path.
- Slot search is a priority encoder over NUM_SLOTS bits, completed within a single cycle.
- Base addresses are computed as 25-bit products; overflow is impossible for the legal parameter range.
- Asserting `rst` mid-frame immediately clears all locks and the published frame; the writer must restart on the next `wr_start`.

## Configuration

- `FRAME_SLOT_DROP_CNT_EN`:
  - Defined: `drop_count` increments on every `frame_dropped` pulse and saturates at 16'hFFFF.
  - Undefined: `drop_count` is tied to 16'h0 and the counter logic is absent. `frame_dropped` still pulses.

## Test plan

- **First frame**: reset, pulse `wr_start` → next cycle `wr_slot`=0, `wr_base`=25'h0. Pulse `wr_done` → `last_slot`=0, `last_valid`=1, one-cycle `frame_ready`.
- **Slot rotation, no readers**: run 3 frames → writer slots 0, 1, 0 (slot 1 is published while frame 3 allocates, so 0 is the lowest free slot).
- **VGA lock**: lock VGA on slot 0, publish slots 1 and 2, then `wr_start` → slot 3 allocated. `rd_base[24:0]`=25'h0 is held throughout.
- **Drop**: NUM_SLOTS=4 with readers locked on slots 0, 1, 2 and `last_slot`=3, then `wr_start` → `wr_valid`=0. `wr_done` → `frame_dropped` pulse, `last_slot` stays 3, `drop_count`=1 when the macro is defined, 0 otherwise.
- **Same-edge collisions**: `rd_lock[1]` on the same edge as a `wr_done` that publishes slot 2 (old `last_slot` 1) → `rd_slot[1]`=1. Simultaneous `rd_lock[0]` and `rd_release[0]` → `rd_valid[0]`=1.
- **Abort and reset**: `wr_start` while WRITING slot 1 → slot 1 never published and a new slot is allocated. Asserting `rst` mid-frame → every output at its reset value in the same cycle.
